// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int XLEN    = 64;
  localparam int DMEM_AW = 32;

  typedef logic [XLEN-1:0] dw_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // An access faults when it is not naturally aligned to its size, uses the
  // reserved encoding, or is a store with an unsigned (load-only) size code.
  function automatic logic access_fault(input logic [2:0] f3, input logic we,
                                        input logic [2:0] off);
    logic flt;
    flt = 1'b0;
    case (f3)
      F3_B, F3_BU: flt = 1'b0;
      F3_H, F3_HU: flt = off[0];
      F3_W, F3_WU: flt = (off[1:0] != 2'b00);
      F3_D:        flt = (off != 3'b000);
      default:     flt = 1'b1;
    endcase
    if (we && f3[2]) begin
      flt = 1'b1;
    end else begin
      flt = flt;
    end
    return flt;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store strobe/data placement and load extract/extend.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      st_funct3,
  input  logic [2:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [7:0]      st_wstrb,
  output logic [XLEN-1:0] st_wdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]      size_mask;
  logic [XLEN-1:0] shifted;

  // Store side: size mask and data both move up to the addressed byte lane.
  always_comb begin
    size_mask = 8'h00;
    case (st_funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      2'b11:   size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
    st_wstrb = size_mask << st_off;
    st_wdata = st_data << {st_off, 3'b000};
  end

  // Load side: bring the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    ld_data = shifted;
    case (ld_funct3)
      F3_B:    ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    ld_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_WU:   ld_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: access FSM, request payload and load result registers.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_M,
  input  logic               req_we_M,
  input  logic [2:0]         funct3_M,
  input  logic [XLEN-1:0]    alu_out_M,
  input  logic [XLEN-1:0]    rs2_data_M,
  output logic               dmem_req_valid,
  input  logic               dmem_req_ready,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [7:0]         dmem_wstrb,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_rsp_valid,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic [XLEN-1:0]    ld_data_M,
  output logic               done_M,
  output logic               stall_M,
  output logic               fault_M
);

  lsu_state_e      state;
  lsu_state_e      state_next;
  logic            req_fault;
  logic            accept;
  logic [2:0]      f3_lat;
  logic [2:0]      off_lat;
  logic [7:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_ext;
  logic            unused_addr_hi;

  // Bits above the memory address width are not part of the issued address.
  assign unused_addr_hi = ^alu_out_M[XLEN-1:DMEM_AW];

  assign req_fault = access_fault(funct3_M, req_we_M, alu_out_M[2:0]);
  assign accept    = (state == IDLE) && req_valid_M;
  assign stall_M   = req_valid_M && (state != DONE);

  // Store payload is computed from live inputs; load extraction from the latched access.
  mem_lsu_align #(.XLEN(XLEN)) u_align (
    .st_funct3 (funct3_M),
    .st_off    (alu_out_M[2:0]),
    .st_data   (rs2_data_M),
    .ld_funct3 (f3_lat),
    .ld_off    (off_lat),
    .ld_rdata  (dmem_rdata),
    .st_wstrb  (st_wstrb),
    .st_wdata  (st_wdata),
    .ld_data   (ld_ext)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: faults finish without touching memory; loads wait for the response.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid_M) begin
          if (req_fault) begin
            state_next = DONE;
          end else begin
            state_next = REQ;
          end
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          if (dmem_we) begin
            state_next = DONE;
          end else begin
            state_next = WAIT_RSP;
          end
        end else begin
          state_next = REQ;
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          state_next = DONE;
        end else begin
          state_next = WAIT_RSP;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the request payload once per accepted access; it stays stable through REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_addr  <= {DMEM_AW{1'b0}};
      dmem_we    <= 1'b0;
      dmem_wstrb <= 8'h00;
      dmem_wdata <= {XLEN{1'b0}};
      f3_lat     <= 3'b000;
      off_lat    <= 3'b000;
    end else if (accept && !req_fault) begin
      dmem_addr  <= {alu_out_M[DMEM_AW-1:3], 3'b000};
      dmem_we    <= req_we_M;
      dmem_wstrb <= st_wstrb;
      dmem_wdata <= st_wdata;
      f3_lat     <= funct3_M;
      off_lat    <= alu_out_M[2:0];
    end
  end

  // Registered status outputs decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req_valid <= 1'b0;
      done_M         <= 1'b0;
      fault_M        <= 1'b0;
    end else begin
      dmem_req_valid <= (state_next == REQ);
      done_M         <= (state_next == DONE);
      fault_M        <= (state_next == DONE) && (state == IDLE);
    end
  end

  // Load result is only updated by a response arriving while waiting for one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_data_M <= {XLEN{1'b0}};
    end else if ((state == WAIT_RSP) && dmem_rsp_valid) begin
      ld_data_M <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a transaction-level reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_M;
  logic        req_we_M;
  logic [2:0]  funct3_M;
  logic [63:0] alu_out_M;
  logic [63:0] rs2_data_M;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wstrb;
  logic [63:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rdata;
  logic [63:0] ld_data_M;
  logic        done_M;
  logic        stall_M;
  logic        fault_M;

  int errors = 0;
  int checks = 0;

  // current transaction as the model sees it
  int          cyc = 0;
  int          exp_done = 0;
  int          req_lo = 1;
  int          req_hi = 0;
  logic        cur_active = 1'b0;
  logic        cur_we = 1'b0;
  logic        cur_fault = 1'b0;
  logic [2:0]  cur_f3 = 3'b000;
  logic [63:0] cur_a = 64'd0;
  logic [63:0] cur_d = 64'd0;
  logic [63:0] cur_ld = 64'd0;
  logic [63:0] exp_ld = 64'd0;
  logic        mon_en = 1'b0;

  logic        snap_seen;
  logic [31:0] snap_addr;
  logic        snap_we;
  logic [7:0]  snap_wstrb;
  logic [63:0] snap_wdata;

  mem_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_M    (req_valid_M),
    .req_we_M       (req_we_M),
    .funct3_M       (funct3_M),
    .alu_out_M      (alu_out_M),
    .rs2_data_M     (rs2_data_M),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .ld_data_M      (ld_data_M),
    .done_M         (done_M),
    .stall_M        (stall_M),
    .fault_M        (fault_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- reference model: plain arithmetic on size = 2**funct3[1:0] bytes ----
  function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [63:0] a);
    if (f3 == 3'b111) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (a % (64'd1 << f3[1:0])) != 64'd0;
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [63:0] a);
    logic [15:0] m;
    m = ((16'd1 << (16'd1 << f3[1:0])) - 16'd1) << (a % 64'd8);
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [63:0] a);
    return d << (64'd8 * (a % 64'd8));
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] f3,
                                         input logic [63:0] a);
    int          nb;
    logic [63:0] t;
    logic [63:0] mask;
    nb = 1 << int'(f3[1:0]);
    t  = rd >> (64'd8 * (a % 64'd8));
    if (nb == 8) return t;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    if (!f3[2] && t[8*nb-1]) return t | ~mask;
    return t & mask;
  endfunction

  // Drive one instruction; the memory side waits rw cycles before ready and
  // answers sw cycles after the earliest legal response cycle.
  task automatic access(input logic we, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] rd, input int rw, input int sw);
    int   vcnt;
    int   rsp_cyc;
    logic hs;
    vcnt = 0;
    rsp_cyc = -1;
    hs = 1'b0;
    @(posedge clk); #1;
    cur_we    = we;
    cur_f3    = f3;
    cur_a     = a;
    cur_d     = d;
    cur_fault = m_fault(we, f3, a);
    cur_ld    = m_load(rd, f3, a);
    exp_done  = cur_fault ? 1 : (we ? 2 + rw : 3 + rw + sw);
    req_lo    = 1;
    req_hi    = cur_fault ? 0 : 1 + rw;
    snap_seen = 1'b0;
    cyc       = 0;
    cur_active = 1'b1;
    req_valid_M = 1'b1;
    req_we_M    = we;
    funct3_M    = f3;
    alu_out_M   = a;
    rs2_data_M  = d;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    while (cyc < exp_done) begin
      @(posedge clk); #1;
      cyc++;
      if (dmem_req_valid) begin
        if (!snap_seen) begin
          snap_seen  = 1'b1;
          snap_addr  = dmem_addr;
          snap_we    = dmem_we;
          snap_wstrb = dmem_wstrb;
          snap_wdata = dmem_wdata;
        end
        if (vcnt >= rw) begin
          dmem_req_ready = 1'b1;
          if (!hs) begin
            hs = 1'b1;
            rsp_cyc = cyc + 1 + sw;
          end
        end else begin
          dmem_req_ready = 1'b0;
        end
        vcnt++;
      end else begin
        dmem_req_ready = 1'b0;
      end
      if (!we && hs && cyc == rsp_cyc) begin
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rd;
      end else begin
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 64'hDEAD_BEEF_0000_0000 ^ 64'(cyc);
      end
    end
    @(posedge clk); #1;
    if (!we && !cur_fault) exp_ld = cur_ld;
    cur_active     = 1'b0;
    req_valid_M    = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    cyc = 0;
  endtask

  // Per-cycle comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("done_M", 64'(done_M), 64'(cur_active && (cyc == exp_done)));
      chk("fault_M", 64'(fault_M), 64'(cur_active && (cyc == exp_done) && cur_fault));
      chk("stall_M", 64'(stall_M), 64'(cur_active && (cyc != exp_done)));
      chk("dmem_req_valid", 64'(dmem_req_valid),
          64'(cur_active && (cyc >= req_lo) && (cyc <= req_hi)));
      chk("ld_data_M", ld_data_M,
          (cur_active && !cur_we && !cur_fault && (cyc >= exp_done)) ? cur_ld : exp_ld);
      if (cur_active && (cyc >= req_lo) && (cyc <= req_hi)) begin
        chk("dmem_addr", 64'(dmem_addr), cur_a & 64'h0000_0000_FFFF_FFF8);
        chk("dmem_we", 64'(dmem_we), 64'(cur_we));
        if (cur_we) begin
          chk("dmem_wstrb", 64'(dmem_wstrb), 64'(m_strb(cur_f3, cur_a)));
          chk("dmem_wdata", dmem_wdata, m_wdata(cur_d, cur_a));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd0);
    chk({tag, "_addr"}, 64'(dmem_addr), 64'd0);
    chk({tag, "_we"}, 64'(dmem_we), 64'd0);
    chk({tag, "_wstrb"}, 64'(dmem_wstrb), 64'd0);
    chk({tag, "_wdata"}, dmem_wdata, 64'd0);
    chk({tag, "_ld_data"}, ld_data_M, 64'd0);
    chk({tag, "_done"}, 64'(done_M), 64'd0);
    chk({tag, "_fault"}, 64'(fault_M), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid_M = 1'b0;
    req_we_M = 1'b0;
    funct3_M = 3'b000;
    alu_out_M = 64'd0;
    rs2_data_M = 64'd0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata = 64'd0;
    snap_seen = 1'b0;
    snap_addr = 32'd0;
    snap_we = 1'b0;
    snap_wstrb = 8'd0;
    snap_wdata = 64'd0;

    // pin the model against hand-computed values
    chk("pin_model_lb", m_load(64'h0000_0000_8000_0000, 3'b000, 64'h1003), 64'hFFFF_FFFF_FFFF_FF80);
    chk("pin_model_lbu", m_load(64'h0000_0000_8000_0000, 3'b100, 64'h1003), 64'h80);
    chk("pin_model_sh_strb", 64'(m_strb(3'b001, 64'h1006)), 64'hC0);
    chk("pin_model_sh_wdata", m_wdata(64'hABCD, 64'h1006), 64'hABCD_0000_0000_0000);
    chk("pin_model_lw_fault", 64'(m_fault(1'b0, 3'b010, 64'h1002)), 64'd1);

    #12;
    chk_all_zero("reset");
    chk("reset_stall", 64'(stall_M), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // 1. LD zero wait states
    access(1'b0, 3'b011, 64'h1000, 64'd0, 64'h1122_3344_5566_7788, 0, 0);
    chk("t1_ld", ld_data_M, 64'h1122_3344_5566_7788);
    // 2. LB / LBU from lane 3
    access(1'b0, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
    chk("t2_lb", ld_data_M, 64'hFFFF_FFFF_FFFF_FF80);
    access(1'b0, 3'b100, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
    chk("t2_lbu", ld_data_M, 64'h0000_0000_0000_0080);
    // 3. SH to lane 6
    access(1'b1, 3'b001, 64'h1006, 64'h0000_0000_0000_ABCD, 64'd0, 0, 0);
    chk("t3_addr", 64'(snap_addr), 64'h1000);
    chk("t3_wstrb", 64'(snap_wstrb), 64'hC0);
    chk("t3_wdata_hi", snap_wdata >> 48, 64'hABCD);
    chk("t3_we", 64'(snap_we), 64'd1);
    chk("t3_ld_kept", ld_data_M, 64'h80);
    // 4. SD with ready held low for 5 cycles
    access(1'b1, 3'b011, 64'h1008, 64'h0123_4567_89AB_CDEF, 64'd0, 5, 0);
    // 5. misaligned LW faults without a memory request
    access(1'b0, 3'b010, 64'h1002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    chk("t5_no_req", 64'(snap_seen), 64'd0);
    chk("t5_ld_kept", ld_data_M, 64'h80);
    // more sizes, lanes, wait states and fault kinds
    access(1'b0, 3'b010, 64'h1004, 64'd0, 64'h9ABC_DEF0_0000_0000, 2, 3);
    access(1'b0, 3'b110, 64'h1004, 64'd0, 64'h9ABC_DEF0_0000_0000, 0, 1);
    access(1'b0, 3'b001, 64'h100A, 64'd0, 64'h1234_8765_4321_0000, 1, 0);
    access(1'b0, 3'b101, 64'h100E, 64'd0, 64'hF00D_0000_0000_0000, 0, 0);
    access(1'b0, 3'b001, 64'h100E, 64'd0, 64'hF00D_0000_0000_0000, 0, 2);
    access(1'b1, 3'b000, 64'h1007, 64'hFFFF_FFFF_FFFF_FF5A, 64'd0, 1, 0);
    access(1'b1, 3'b010, 64'h100C, 64'h5555_5555_CAFE_F00D, 64'd0, 0, 0);
    access(1'b0, 3'b111, 64'h1000, 64'd0, 64'd0, 0, 0);
    access(1'b1, 3'b100, 64'h1001, 64'h77, 64'd0, 0, 0);
    access(1'b0, 3'b011, 64'h1004, 64'd0, 64'd0, 0, 0);
    access(1'b1, 3'b010, 64'h1001, 64'h1, 64'd0, 0, 0);

    // 6. reset while waiting for a load response, then a late response
    mon_en = 1'b0;
    @(posedge clk); #1;
    req_valid_M = 1'b1;
    req_we_M = 1'b0;
    funct3_M = 3'b011;
    alu_out_M = 64'h2000;
    @(posedge clk); #1;
    chk("t6_req_valid", 64'(dmem_req_valid), 64'd1);
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    chk("t6_waiting_no_done", 64'(done_M), 64'd0);
    chk("t6_waiting_stall", 64'(stall_M), 64'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("t6_in_reset");
    req_valid_M = 1'b0;
    exp_ld = 64'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all_zero("t6_after");
      chk("t6_after_stall", 64'(stall_M), 64'd0);
    end
    mon_en = 1'b1;
    access(1'b0, 3'b011, 64'h2000, 64'd0, 64'h0F0E_0D0C_0B0A_0908, 0, 0);
    chk("t6_next_ld", ld_data_M, 64'h0F0E_0D0C_0B0A_0908);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
